// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART blocks.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_mode_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BRK_WAIT
    } rx_state_t;

    typedef enum logic [1:0] {HS_EMPTY, HS_VALID, HS_HANDSHAKE} hs_state_t;

    // Clocks per oversample tick, rounded to nearest, never below 1.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int den;
        int d;
        den = baud * oversample;
        d   = (clk_freq + den / 2) / den;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every DIV clks, held in phase while clr is high.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic Reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            cnt <= '0;
        else if (clr || cnt == CW'(DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = !clr && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority vote, break detection and a
// one-word holding register released through a four-phase Receive/Received handshake.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int           CLK_FREQ    = 100_000_000,
    parameter int           BAUD        = 115_200,
    parameter int           OVERSAMPLE  = 16,
    parameter int           DATA_BITS   = 8,
    parameter parity_mode_t PARITY_MODE = PAR_ODD,
    parameter int           STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Sin,
    input  logic                 Received,
    output logic                 Receive,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 parityErr,
    output logic                 frameErr,
    output logic                 overrun,
    output logic                 breakDet
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW    = $clog2(OVERSAMPLE);
    localparam int BW    = $clog2(DATA_BITS);
    localparam int S_LO  = OVERSAMPLE / 2 - 1;
    localparam int S_MID = OVERSAMPLE / 2;
    localparam int S_HI  = OVERSAMPLE / 2 + 1;
    localparam int S_END = OVERSAMPLE - 1;
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 perr;
        logic                 ferr;
    } rx_word_t;

    logic sin_m, sin_s;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sin_m <= 1'b1;
            sin_s <= 1'b1;
        end else begin
            sin_m <= Sin;
            sin_s <= sin_m;
        end
    end

    rx_state_t rx_state;
    logic      tick, tick_clr;

    assign tick_clr = (rx_state == RX_IDLE);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .Reset (Reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bcnt;
    logic                 scnt;
    logic                 v_lo, v_mid;
    logic [DATA_BITS-1:0] shreg;
    logic                 pbit, perr_pend, ferr_pend;
    logic                 fr_done;
    rx_word_t             fr_word;

    logic vote, at_vote, at_end, exp_par, brk_cond;

    // Third sample is the live synchronised value; the first two were latched earlier.
    assign vote     = (v_lo & v_mid) | (v_lo & sin_s) | (v_mid & sin_s);
    assign at_vote  = tick && (tcnt == TW'(S_HI));
    assign at_end   = tick && (tcnt == TW'(S_END));
    assign exp_par  = (PARITY_MODE == PAR_EVEN) ? ^shreg : ~^shreg;
    assign brk_cond = (shreg == '0) && (PARITY_MODE == PAR_NONE || !pbit) && !vote;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rx_state  <= RX_IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            scnt      <= 1'b0;
            v_lo      <= 1'b1;
            v_mid     <= 1'b1;
            shreg     <= '0;
            pbit      <= 1'b0;
            perr_pend <= 1'b0;
            ferr_pend <= 1'b0;
            fr_done   <= 1'b0;
            fr_word   <= '0;
            breakDet  <= 1'b0;
        end else begin
            fr_done  <= 1'b0;
            breakDet <= 1'b0;
            if (tick && tcnt == TW'(S_LO))  v_lo  <= sin_s;
            if (tick && tcnt == TW'(S_MID)) v_mid <= sin_s;
            if (tick) tcnt <= (tcnt == TW'(S_END)) ? '0 : tcnt + TW'(1);
            case (rx_state)
                RX_IDLE: begin
                    if (!sin_s) begin
                        rx_state  <= RX_START;
                        tcnt      <= '0;
                        bcnt      <= '0;
                        scnt      <= 1'b0;
                        pbit      <= 1'b0;
                        perr_pend <= 1'b0;
                        ferr_pend <= 1'b0;
                    end
                end
                RX_START: begin
                    if (at_vote && vote)
                        rx_state <= RX_IDLE;
                    else if (at_end)
                        rx_state <= RX_DATA;
                end
                RX_DATA: begin
                    if (at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (at_end) begin
                        if (bcnt == BW'(DATA_BITS - 1)) begin
                            bcnt     <= '0;
                            rx_state <= (PARITY_MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
                        end else begin
                            bcnt <= bcnt + BW'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (at_vote) begin
                        pbit      <= vote;
                        perr_pend <= (vote != exp_par);
                    end else if (at_end) begin
                        rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // The frame completes at the last vote of the final stop bit, not at bit end.
                    if (at_vote) begin
                        if (!scnt && brk_cond) begin
                            breakDet <= 1'b1;
                            rx_state <= RX_BRK_WAIT;
                        end else if (scnt == LAST_STOP) begin
                            fr_done      <= 1'b1;
                            fr_word.data <= shreg;
                            fr_word.perr <= perr_pend;
                            fr_word.ferr <= ferr_pend | !vote;
                            rx_state     <= RX_IDLE;
                        end else begin
                            ferr_pend <= ferr_pend | !vote;
                        end
                    end else if (at_end) begin
                        scnt <= scnt + 1'b1;
                    end
                end
                RX_BRK_WAIT: begin
                    if (sin_s) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    hs_state_t hs_state;
    rx_word_t  held;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            hs_state <= HS_EMPTY;
            held     <= '0;
            Receive  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            case (hs_state)
                HS_EMPTY: begin
                    if (fr_done) begin
                        held     <= fr_word;
                        hs_state <= HS_VALID;
                        Receive  <= 1'b1;
                    end
                end
                HS_VALID: begin
                    if (fr_done) overrun <= 1'b1;
                    if (Received) begin
                        hs_state <= HS_HANDSHAKE;
                        Receive  <= 1'b0;
                    end
                end
                HS_HANDSHAKE: begin
                    // Consumer already released: a completion here is a fresh load, not a drop.
                    if (!Received) begin
                        if (fr_done) begin
                            held     <= fr_word;
                            hs_state <= HS_VALID;
                            Receive  <= 1'b1;
                        end else begin
                            hs_state <= HS_EMPTY;
                            overrun  <= 1'b0;
                        end
                    end else if (fr_done) begin
                        overrun <= 1'b1;
                    end
                end
                default: hs_state <= HS_EMPTY;
            endcase
        end
    end

    assign Dout      = held.data;
    assign parityErr = held.perr;
    assign frameErr  = held.ferr;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four configurations (8O1, 8E1, 8N2, 9N1) at 16 clks/bit.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int CF = 1_600_000;
    localparam int BR = 100_000;
    localparam int BITCLK = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic ack [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic rcv [4];
    logic perr [4];
    logic ferr [4];
    logic ovr [4];
    logic brk [4];
    logic [7:0] d0, d1, d2;
    logic [8:0] d3;
    logic [8:0] dout [4];

    assign dout[0] = {1'b0, d0};
    assign dout[1] = {1'b0, d1};
    assign dout[2] = {1'b0, d2};
    assign dout[3] = d3;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY_MODE(PAR_ODD), .STOP_BITS(1)) u_o1 (
        .clk(clk), .Reset(rst), .Sin(sin[0]), .Received(ack[0]), .Receive(rcv[0]),
        .Dout(d0), .parityErr(perr[0]), .frameErr(ferr[0]), .overrun(ovr[0]), .breakDet(brk[0]));
    uart_rx_param #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY_MODE(PAR_EVEN), .STOP_BITS(1)) u_e1 (
        .clk(clk), .Reset(rst), .Sin(sin[1]), .Received(ack[1]), .Receive(rcv[1]),
        .Dout(d1), .parityErr(perr[1]), .frameErr(ferr[1]), .overrun(ovr[1]), .breakDet(brk[1]));
    uart_rx_param #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY_MODE(PAR_NONE), .STOP_BITS(2)) u_n2 (
        .clk(clk), .Reset(rst), .Sin(sin[2]), .Received(ack[2]), .Receive(rcv[2]),
        .Dout(d2), .parityErr(perr[2]), .frameErr(ferr[2]), .overrun(ovr[2]), .breakDet(brk[2]));
    uart_rx_param #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(16), .DATA_BITS(9),
                    .PARITY_MODE(PAR_NONE), .STOP_BITS(1)) u_n9 (
        .clk(clk), .Reset(rst), .Sin(sin[3]), .Received(ack[3]), .Receive(rcv[3]),
        .Dout(d3), .parityErr(perr[3]), .frameErr(ferr[3]), .overrun(ovr[3]), .breakDet(brk[3]));

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    longint rise_cyc [4] = '{0, 0, 0, 0};
    int     rcv_cnt [4] = '{0, 0, 0, 0};
    int     brk_cnt [4] = '{0, 0, 0, 0};
    logic   rcv_q [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rcv[i] && !rcv_q[i]) begin
                rise_cyc[i] <= cyc;
                rcv_cnt[i]  <= rcv_cnt[i] + 1;
            end
            if (brk[i]) brk_cnt[i] <= brk_cnt[i] + 1;
            rcv_q[i] <= rcv[i];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input int idx, input logic b);
        sin[idx] = b;
        repeat (BITCLK) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int idx, input int nb, input logic [8:0] data,
                              input bit has_par, input logic pb, input int nstop,
                              input logic stopv, input int idle_bits, output longint t0);
        @(posedge clk);
        #1;
        t0 = cyc;
        drive_bit(idx, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(idx, data[i]);
        if (has_par) drive_bit(idx, pb);
        for (int i = 0; i < nstop; i++) drive_bit(idx, stopv);
        for (int i = 0; i < idle_bits; i++) drive_bit(idx, 1'b1);
    endtask

    // Receive must rise 1 clk after the last vote of the final stop bit: 16*F-2 clks after the start edge.
    task automatic expect_word(input int idx, input string tag, input logic [8:0] d,
                               input logic pe, input logic fe, input int nframe, input longint t0);
        chk({tag, " Receive"}, rcv[idx], 1);
        chk({tag, " Dout"}, dout[idx], d);
        chk({tag, " parityErr"}, perr[idx], pe);
        chk({tag, " frameErr"}, ferr[idx], fe);
        chk({tag, " latency"}, rise_cyc[idx] - t0, 64'(BITCLK * nframe - 2));
    endtask

    task automatic do_ack(input int idx, input string tag);
        ack[idx] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " Receive drop"}, rcv[idx], 0);
        ack[idx] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input int idx, input string tag);
        chk({tag, " Receive"}, rcv[idx], 0);
        chk({tag, " Dout"}, dout[idx], 0);
        chk({tag, " parityErr"}, perr[idx], 0);
        chk({tag, " frameErr"}, ferr[idx], 0);
        chk({tag, " overrun"}, ovr[idx], 0);
        chk({tag, " breakDet"}, brk[idx], 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pb;
        logic       stopv;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t       tbl [6];
    longint     t0;
    int         rc0, bc0;
    logic [7:0] rd;
    logic       rpb, rsv, rpe;
    int         ones;

    initial begin
        tbl[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        tbl[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
        tbl[5] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};

        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk_zero(i, $sformatf("reset dut%0d", i));
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Short low glitch is a false start: nothing delivered, no flags.
        rc0 = rcv_cnt[0];
        sin[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        sin[0] = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("glitch rcv count", rcv_cnt[0] - rc0, 0);
        chk_zero(0, "glitch");

        send_frame(0, 8, 9'h0A5, 1, 1'b1, 1, 1'b1, 1, t0);
        expect_word(0, "8O1 A5", 9'h0A5, 1'b0, 1'b0, 11, t0);
        do_ack(0, "8O1 A5");

        for (int n = 0; n < 10; n++) begin
            rd   = 8'($urandom);
            ones = $countones(rd);
            rpb  = (ones % 2 == 0);
            if ($urandom_range(0, 3) == 0) rpb = !rpb;
            rsv  = ($urandom_range(0, 3) != 0);
            if (rd == 8'h00 && !rpb) rsv = 1'b1;
            rpe  = ((ones + int'(rpb)) % 2 == 0);
            send_frame(0, 8, {1'b0, rd}, 1, rpb, 1, rsv, 1, t0);
            expect_word(0, $sformatf("rnd%0d", n), {1'b0, rd}, rpe, !rsv, 11, t0);
            do_ack(0, $sformatf("rnd%0d", n));
        end

        for (int i = 0; i < 6; i++) begin
            send_frame(1, 8, {1'b0, tbl[i].data}, 1, tbl[i].pb, 1, tbl[i].stopv, 1, t0);
            expect_word(1, $sformatf("8E1 vec%0d", i), {1'b0, tbl[i].exp_d},
                        tbl[i].exp_pe, tbl[i].exp_fe, 11, t0);
            do_ack(1, $sformatf("8E1 vec%0d", i));
        end

        rc0 = rcv_cnt[2];
        bc0 = brk_cnt[2];
        send_frame(2, 8, 9'h000, 0, 1'b0, 2, 1'b0, 0, t0);
        repeat (40 * BITCLK) @(posedge clk);
        #1;
        sin[2] = 1'b1;
        repeat (48) @(posedge clk);
        #1;
        chk("break pulses", brk_cnt[2] - bc0, 1);
        chk("break rcv count", rcv_cnt[2] - rc0, 0);
        chk("break Receive", rcv[2], 0);
        send_frame(2, 8, 9'h055, 0, 1'b0, 2, 1'b1, 1, t0);
        expect_word(2, "8N2 55", 9'h055, 1'b0, 1'b0, 11, t0);
        do_ack(2, "8N2 55");

        send_frame(0, 8, 9'h011, 1, 1'b1, 1, 1'b1, 1, t0);
        expect_word(0, "ovr 11", 9'h011, 1'b0, 1'b0, 11, t0);
        send_frame(0, 8, 9'h022, 1, 1'b1, 1, 1'b1, 1, t0);
        chk("ovr Dout held", dout[0], 9'h011);
        chk("ovr overrun set", ovr[0], 1);
        chk("ovr Receive", rcv[0], 1);
        ack[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ovr ack Receive", rcv[0], 0);
        chk("ovr during handshake", ovr[0], 1);
        ack[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ovr cleared", ovr[0], 0);
        chk("ovr Receive idle", rcv[0], 0);

        send_frame(3, 9, 9'h1FF, 0, 1'b0, 1, 1'b1, 1, t0);
        expect_word(3, "9N1 1FF", 9'h1FF, 1'b0, 1'b0, 11, t0);
        rc0 = rcv_cnt[3];
        fork
            send_frame(3, 9, 9'h1FF, 0, 1'b0, 1, 1'b1, 2, t0);
            begin
                repeat (5 * BITCLK) @(posedge clk);
                #1;
                rst = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                chk_zero(3, "midframe reset");
                rst = 1'b0;
            end
        join
        repeat (40) @(posedge clk);
        #1;
        chk("partial frame rcv count", rcv_cnt[3] - rc0, 0);
        chk_zero(3, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the team's fixed 8-bit UART receiver.
- Configurable data width, parity mode (none/even/odd) and stop-bit count; 16x oversampling with 3-sample majority vote; false-start rejection.
- Flags framing error and break; a one-word holding register keeps reception running during the four-phase Receive/Received handshake, with overrun detection.
- Sits between the board RX pin and the command/heater-control logic.

Parameters:
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- BAUD, 115_200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; even, >= 8.
- DATA_BITS, 8, payload width, 5..9.
- PARITY_MODE, PAR_ODD, PAR_NONE / PAR_EVEN / PAR_ODD.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Sin  in  1  asynchronous serial line, idle high.
- Received  in  1  consumer acknowledge for the four-phase handshake.
- Receive  out  1  held word valid.
- Dout  out  DATA_BITS  held word, LSB = first bit received.
- parityErr  out  1  parity mismatch on held word; 0 when PARITY_MODE = PAR_NONE.
- frameErr  out  1  a stop bit sampled low on held word.
- overrun  out  1  at least one frame dropped while holding register was full.
- breakDet  out  1  one-clk pulse per break condition.

Behaviour:
- Reset, asynchronous: all outputs 0, Dout 0, both FSMs idle, tick counter 0, Sin synchroniser flops set to 1.
- Sin passes through a 2-flop synchroniser; all sampling uses the synchronised value (2-clk input latency).
- Tick generator: DIV = round(CLK_FREQ / (BAUD*OVERSAMPLE)), minimum 1.
  - One-clk tick every DIV clks; counter cleared whenever the RX FSM is in IDLE.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: synchronised Sin = 0 -> START; tick counter restarts.
- Bit sampling, all states: samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit; majority vote of the 3 is the bit value.
- START: voted 0 -> DATA at the bit end; voted 1 -> IDLE (false start, no flags).
- DATA: DATA_BITS bits, LSB first, into the shift register -> PARITY, or STOP if PAR_NONE.
- PARITY: expected parity = XOR of data (even mode) or XNOR of data (odd mode); mismatch sets the pending parityErr.
- STOP: each stop bit voted; any 0 sets the pending frameErr. Completion occurs at the last vote sample of the final stop bit; FSM does not wait for bit end -> IDLE.
- Break: all data bits 0, parity bit 0 (if present) and first stop bit 0.
  - Pulse breakDet for 1 clk, discard the frame, go to BRK_WAIT.
  - BRK_WAIT: stay until synchronised Sin = 1 -> IDLE.
- Handshake FSM states: EMPTY, VALID, HANDSHAKE.
  - Completion in EMPTY: load Dout, parityErr, frameErr on the next clk; Receive = 1 from that clk (latency 1 clk after completion).
  - VALID: Receive = 1; Received = 1 -> HANDSHAKE with Receive = 0 next clk.
  - HANDSHAKE: Received = 0 -> EMPTY. The held outputs stay stable until the next load.
- Completion while the register is VALID, or HANDSHAKE with Received = 1: frame dropped, overrun set to 1.
  - overrun clears when HANDSHAKE exits to EMPTY with no simultaneous load.
- Simultaneous completion with HANDSHAKE and Received = 0: load accepted, no overrun; next state is VALID.
- Received high in EMPTY: ignored.
- Reset asserted mid-frame or mid-handshake: immediate return to reset values; a partial frame is never delivered.

Decomposition:
- Package uart_pkg:
  - parity_mode_t enum {PAR_NONE, PAR_EVEN, PAR_ODD}.
  - rx_state_t and hs_state_t enums.
  - Function calc_div(CLK_FREQ, BAUD, OVERSAMPLE).
- Sub-module uart_baud_tick: parametrised divisor, with ports clk, Reset, clr, tick.
  - Reused later by a matching parametrised transmitter.
- Synchroniser, voter and both FSMs stay in uart_rx_param.

Test Plan (CLK_FREQ = 1_600_000, BAUD = 100_000, OVERSAMPLE = 16, giving DIV = 1 and 16 clks/bit, unless stated):
- 8O1, send 0xA5 (parity bit 1), hold Received low -> Receive = 1, Dout = 0xA5, parityErr = 0, frameErr = 0, 1 clk after the stop-bit vote.
- 8E1, send 0x3C with parity bit 1 -> Dout = 0x3C, parityErr = 1. Then send 0x3C with stop bit 0 -> frameErr = 1.
- 6-cycle low glitch on Sin, then idle -> no Receive, FSM back in IDLE, no flags.
- 8N2, send 0x00 with all-zero stop bits, held low for 40 bit times -> breakDet pulses 1 clk; no Receive; next valid 0x55 received normally.
- Receive 0x11, never acknowledge, send 0x22 -> Dout stays 0x11, overrun = 1. Complete the handshake -> overrun = 0, Receive = 0.
- DATA_BITS = 9, PAR_NONE, send 0x1FF; assert Reset mid-data on a repeat frame -> first Dout = 0x1FF; after Reset all outputs 0 and the partial frame is never delivered.
